// File: rtl/rng_pkg.sv
// Shared constants and types for the LFSR range generator: default polynomial,
// default seed, draw FSM encoding and the card-draw ranges.
package rng_pkg;

    localparam logic [31:0] DEFAULT_TAPS = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_ACE1;

    localparam int DECK_RANGE = 52;
    localparam int RANK_RANGE = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        HOLD = 2'd2
    } draw_state_t;

endpackage

// File: rtl/lfsr_range_gen_if.sv
// Request/response handshake bundle between the dealer and the range generator.
interface lfsr_range_gen_if #(
    parameter int OUT_W = 6
) ();

    logic             req_valid;
    logic             req_ready;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] value;
    logic             fallback;

    modport master (
        output req_valid,
        output out_ready,
        input  req_ready,
        input  out_valid,
        input  value,
        input  fallback
    );

    modport slave (
        input  req_valid,
        input  out_ready,
        output req_ready,
        output out_valid,
        output value,
        output fallback
    );

endinterface

// File: rtl/lfsr_core.sv
// Free-running Galois LFSR with runtime reseed; a zero seed is replaced by SEED
// and the state is guarded so it can never lock up at all-zero.
module lfsr_core #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = 32'h8020_0003,
    parameter logic [WIDTH-1:0] SEED  = 32'hACE1_ACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_next;

    // Next-state selection: reseed wins over the shift, all-zero falls back to SEED.
    always_comb begin
        w_shift = (r_state >> 1) ^ (r_state[0] ? TAPS : {WIDTH{1'b0}});
        w_next  = w_shift;
        if (seed_load) begin
            w_next = (seed_in == {WIDTH{1'b0}}) ? SEED : seed_in;
        end else begin
            w_next = w_shift;
        end
        if (w_next == {WIDTH{1'b0}}) begin
            w_next = SEED;
        end else begin
            w_next = w_next;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= SEED;
        end else begin
            r_state <= w_next;
        end
    end

    assign state = r_state;

endmodule

// File: rtl/lfsr_range_gen.sv
// Uniform integer source in [0, RANGE) built on a Galois LFSR, using rejection
// sampling with a bounded number of tries and a wrap-around fallback.
module lfsr_range_gen
    import rng_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] TAPS      = DEFAULT_TAPS,
    parameter logic [WIDTH-1:0] SEED      = DEFAULT_SEED,
    parameter int               RANGE     = DECK_RANGE,
    parameter int               OUT_W     = $clog2(RANGE),
    parameter int               MAX_TRIES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 seed_load,
    input  logic [WIDTH-1:0]     seed_in,
    lfsr_range_gen_if.slave      bus,
    output logic [WIDTH-1:0]     randnum
);

    localparam int                 TRY_W    = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0]   LAST_TRY = TRY_W'(MAX_TRIES - 1);
    localparam logic [OUT_W:0]     RANGE_V  = (OUT_W + 1)'(RANGE);

    draw_state_t      r_state,  w_next_state;
    logic [TRY_W-1:0] r_tries,  w_next_tries;
    logic [OUT_W-1:0] r_value,  w_next_value;
    logic             r_fallback, w_next_fallback;
    logic             r_out_valid;
    logic             r_req_ready;

    logic [WIDTH-1:0] w_state;
    logic [OUT_W-1:0] w_cand;
    logic             w_cand_ok;
    logic [OUT_W-1:0] w_wrapped;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .state     (w_state)
    );

    // c < 2^OUT_W <= 2*RANGE, so subtracting RANGE once always lands in range.
    assign w_cand    = w_state[OUT_W-1:0];
    assign w_cand_ok = ({1'b0, w_cand} < RANGE_V);
    assign w_wrapped = OUT_W'({1'b0, w_cand} - RANGE_V);

    // Draw FSM next-state and datapath decode.
    always_comb begin
        w_next_state    = r_state;
        w_next_tries    = r_tries;
        w_next_value    = r_value;
        w_next_fallback = r_fallback;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_next_state = DRAW;
                    w_next_tries = {TRY_W{1'b0}};
                end else begin
                    w_next_state = IDLE;
                end
            end
            DRAW: begin
                if (w_cand_ok) begin
                    w_next_value    = w_cand;
                    w_next_fallback = 1'b0;
                    w_next_state    = HOLD;
                end else if (r_tries == LAST_TRY) begin
                    w_next_value    = w_wrapped;
                    w_next_fallback = 1'b1;
                    w_next_state    = HOLD;
                end else begin
                    w_next_tries = r_tries + TRY_W'(1);
                    w_next_state = DRAW;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = HOLD;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // FSM, try counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_tries     <= {TRY_W{1'b0}};
            r_value     <= {OUT_W{1'b0}};
            r_fallback  <= 1'b0;
            r_out_valid <= 1'b0;
            r_req_ready <= 1'b1;
        end else begin
            r_state     <= w_next_state;
            r_tries     <= w_next_tries;
            r_value     <= w_next_value;
            r_fallback  <= w_next_fallback;
            r_out_valid <= (w_next_state == HOLD);
            r_req_ready <= (w_next_state == IDLE);
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.value     = r_value;
    assign bus.fallback  = r_fallback;
    assign randnum       = w_state;

endmodule

// File: tb/tb_lfsr_range_gen.sv
// Directed bench for lfsr_range_gen: hand-computed LFSR and draw results, plus a
// long run of requests checking every returned value stays below RANGE.
module tb_lfsr_range_gen;

    logic        clk;
    logic        rst_n;
    logic        seed_load;
    logic [31:0] seed_in;
    logic [31:0] randnum;
    logic [31:0] randnum_fb;

    int n_pass  = 0;
    int n_total = 0;

    lfsr_range_gen_if #(.OUT_W(6)) bus ();
    lfsr_range_gen_if #(.OUT_W(6)) bus_fb ();

    lfsr_range_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .bus       (bus.slave),
        .randnum   (randnum)
    );

    lfsr_range_gen #(.MAX_TRIES(1)) dut_fb (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .bus       (bus_fb.slave),
        .randnum   (randnum_fb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        logic [5:0] held;
        int         lat;

        rst_n            = 1'b0;
        seed_load        = 1'b0;
        seed_in          = 32'h0;
        bus.req_valid    = 1'b0;
        bus.out_ready    = 1'b1;
        bus_fb.req_valid = 1'b0;
        bus_fb.out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset_randnum",   64'(randnum),       64'hACE1ACE1);
        chk("reset_req_ready", 64'(bus.req_ready), 64'd1);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_value",     64'(bus.value),     64'd0);
        chk("reset_fallback",  64'(bus.fallback),  64'd0);

        // Seed 1 and free-run
        seed_load = 1'b1; seed_in = 32'h1;
        tick();
        seed_load = 1'b0;
        chk("seq0", 64'(randnum), 64'h00000001);
        tick(); chk("seq1", 64'(randnum), 64'h80200003);
        tick(); chk("seq2", 64'(randnum), 64'hC0300002);
        tick(); chk("seq3", 64'(randnum), 64'h60180001);

        // Accept path: seed 0x35 -> candidate 25
        seed_load = 1'b1; seed_in = 32'h35;
        tick();
        seed_load = 1'b0;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        chk("acc_randnum",   64'(randnum),       64'h80200019);
        chk("acc_busy",      64'(bus.req_ready), 64'd0);
        chk("acc_not_yet",   64'(bus.out_valid), 64'd0);
        tick();
        chk("acc_valid",     64'(bus.out_valid), 64'd1);
        chk("acc_value",     64'(bus.value),     64'd25);
        chk("acc_fallback",  64'(bus.fallback),  64'd0);
        tick();
        chk("acc_done_valid", 64'(bus.out_valid), 64'd0);
        chk("acc_done_ready", 64'(bus.req_ready), 64'd1);

        // Reject path on main DUT, fallback path on MAX_TRIES=1 DUT: seed 0x7E
        seed_load = 1'b1; seed_in = 32'h7E;
        tick();
        seed_load = 1'b0;
        bus.req_valid    = 1'b1;
        bus_fb.req_valid = 1'b1;
        tick();
        bus.req_valid    = 1'b0;
        bus_fb.req_valid = 1'b0;
        chk("rej_e0_valid", 64'(bus.out_valid), 64'd0);
        tick();
        chk("rej_e1_valid", 64'(bus.out_valid),    64'd0);
        chk("rej_state",    64'(randnum),          64'h8020001C);
        chk("fb_valid",     64'(bus_fb.out_valid), 64'd1);
        chk("fb_value",     64'(bus_fb.value),     64'd11);
        chk("fb_flag",      64'(bus_fb.fallback),  64'd1);
        tick();
        chk("rej_valid",    64'(bus.out_valid), 64'd1);
        chk("rej_value",    64'(bus.value),     64'd28);
        chk("rej_fallback", 64'(bus.fallback),  64'd0);
        tick();

        // Zero seed substitutes SEED
        seed_load = 1'b1; seed_in = 32'h0;
        tick();
        seed_load = 1'b0;
        chk("zero_seed", 64'(randnum), 64'hACE1ACE1);

        // Backpressure: state 0xD650D673 gives candidate 51 (RANGE-1)
        bus.out_ready = 1'b0;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        tick();
        chk("bp_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_value", 64'(bus.value),     64'd51);
        held = bus.value;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_hold_value", 64'(bus.value),     64'(held));
            chk("bp_hold_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 64'(bus.out_valid), 64'd0);
        chk("bp_release_ready", 64'(bus.req_ready), 64'd1);

        // Reset one cycle after acceptance discards the draw
        seed_load = 1'b1; seed_in = 32'h7E;
        tick();
        seed_load = 1'b0;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_draw_valid",   64'(bus.out_valid), 64'd0);
        chk("rst_draw_randnum", 64'(randnum),       64'hACE1ACE1);
        chk("rst_draw_ready",   64'(bus.req_ready), 64'd1);

        // Long random run: every value below RANGE within MAX_TRIES cycles
        for (int r = 0; r < 10000; r++) begin
            if ((r % 97) == 0) begin
                seed_load = 1'b1;
                seed_in   = $urandom;
                tick();
                seed_load = 1'b0;
            end
            bus.req_valid = 1'b1;
            tick();
            bus.req_valid = 1'b0;
            lat = 0;
            while (!bus.out_valid && lat < 20) begin
                tick();
                lat++;
            end
            if (!bus.out_valid) begin
                chk("rand_timeout", 64'(bus.out_valid), 64'd1);
            end else begin
                chk("rand_in_range", 64'(bus.value < 6'd52), 64'd1);
                chk("rand_latency",  64'(lat >= 1 && lat <= 16), 64'd1);
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
